// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph codes in active-high gfedcba order, used by
// both the display encoder and the scan capture monitor.
package seg7_pkg;

    localparam int unsigned DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] glyphOf(input logic [3:0] nibble);
        case (nibble)
            4'h0:    glyphOf = SEG_0;
            4'h1:    glyphOf = SEG_1;
            4'h2:    glyphOf = SEG_2;
            4'h3:    glyphOf = SEG_3;
            4'h4:    glyphOf = SEG_4;
            4'h5:    glyphOf = SEG_5;
            4'h6:    glyphOf = SEG_6;
            4'h7:    glyphOf = SEG_7;
            4'h8:    glyphOf = SEG_8;
            4'h9:    glyphOf = SEG_9;
            4'hA:    glyphOf = SEG_A;
            4'hB:    glyphOf = SEG_B;
            4'hC:    glyphOf = SEG_C;
            4'hD:    glyphOf = SEG_D;
            4'hE:    glyphOf = SEG_E;
            default: glyphOf = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse glyph lookup: maps an active-high gfedcba code back to its hex nibble and
// flags the all-off and not-a-glyph cases.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_illegal
);

    always_comb begin
        nibble     = 4'h0;
        is_blank   = (code == SEG_BLANK);
        is_illegal = (code != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (code == glyphOf(4'(i))) begin
                nibble     = 4'(i);
                is_illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Display monitor: samples a multiplexed active-low seven-segment bus and rebuilds the
// per-digit nibble, dp, blank and error state once each scan slot has been stable.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = DIGITS_DEFAULT,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    input  logic                  dp_n,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic [DIGITS-1:0]     valid,
    output logic                  frame_done
);

    localparam int unsigned SW = DIGITS + 8;

    logic [SW-1:0]       sQ, prevQ;
    logic [CNT_W-1:0]    cntQ, cntD;
    logic                accQ, accD;
    logic [DIGITS-1:0]   seenQ, seenD;
    logic [4*DIGITS-1:0] hexQ, hexD;
    logic [DIGITS-1:0]   dpQ, dpD, blankQ, blankD, errQ, errD, validQ, validD;
    logic                frameQ, frameD;

    logic [DIGITS-1:0]   anAct;
    logic                oneHot, changed, accEff, accept;
    logic [3:0]          decNibble;
    logic                decBlank, decIllegal;

    seg7_pattern_decode u_decode (
        .code       (~sQ[7:1]),
        .nibble     (decNibble),
        .is_blank   (decBlank),
        .is_illegal (decIllegal)
    );

    always_comb begin
        anAct   = ~sQ[SW-1:8];
        oneHot  = (anAct != '0) && ((anAct & (anAct - DIGITS'(1))) == '0);
        changed = (sQ != prevQ);

        if (changed) begin
            cntD = CNT_W'(1);
        end else if (cntQ < CNT_W'(STABLE_CYCLES)) begin
            cntD = cntQ + CNT_W'(1);
        end else begin
            cntD = cntQ;
        end

        // A new run clears the flag in the same cycle it could be accepted (STABLE_CYCLES=1).
        accEff = changed ? 1'b0 : accQ;
        accept = oneHot && !accEff && (cntD == CNT_W'(STABLE_CYCLES));
        accD   = accEff | accept;

        hexD   = hexQ;
        dpD    = dpQ;
        blankD = blankQ;
        errD   = errQ;
        validD = validQ;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (accept && anAct[i]) begin
                dpD[i]    = ~sQ[0];
                validD[i] = 1'b1;
                blankD[i] = decBlank;
                errD[i]   = decIllegal;
                if (!decBlank && !decIllegal) begin
                    hexD[4*i +: 4] = decNibble;
                end
            end
        end

        seenD  = seenQ;
        frameD = 1'b0;
        if (accept) begin
            seenD = seenQ | anAct;
            if (&seenD) begin
                frameD = 1'b1;
                seenD  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sQ     <= '1;
            prevQ  <= '1;
            cntQ   <= '0;
            accQ   <= 1'b0;
            seenQ  <= '0;
            hexQ   <= '0;
            dpQ    <= '0;
            blankQ <= '0;
            errQ   <= '0;
            validQ <= '0;
            frameQ <= 1'b0;
        end else begin
            sQ     <= {an_n, seg_n, dp_n};
            prevQ  <= sQ;
            cntQ   <= cntD;
            accQ   <= accD;
            seenQ  <= seenD;
            hexQ   <= hexD;
            dpQ    <= dpD;
            blankQ <= blankD;
            errQ   <= errD;
            validQ <= validD;
            frameQ <= frameD;
        end
    end

    assign hex_out    = hexQ;
    assign dp_out     = dpQ;
    assign blank      = blankQ;
    assign err        = errQ;
    assign valid      = validQ;
    assign frame_done = frameQ;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: drives scan patterns on the active-low bus and
// checks captured digit state against hand-computed values.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [15:0] hex_out;
    logic [3:0]  dp_out, blank, err, valid;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int fdCount = 0;

    seg7_scan_capture dut (
        .clk        (clk),
        .rst        (rst),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .blank      (blank),
        .err        (err),
        .valid      (valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fdCount++;

    task automatic drive(input logic [3:0] an, input logic [6:0] code, input logic dpOn);
        an_n  = an;
        seg_n = ~code;
        dp_n  = ~dpOn;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b1111, 7'h00, 1'b0);
        tick(2);
        rst = 1'b0;

        // Idle bus
        tick(50);
        chk("idle_hex", 32'(hex_out), 32'h0000);
        chk("idle_dp", 32'(dp_out), 32'h0);
        chk("idle_blank", 32'(blank), 32'h0);
        chk("idle_err", 32'(err), 32'h0);
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_frames", 32'(fdCount), 32'd0);

        // Single capture latency
        drive(4'b1110, 7'h4F, 1'b1);
        tick(4);
        chk("lat_before_valid", 32'(valid), 32'h0);
        tick(1);
        chk("lat_hex", 32'(hex_out), 32'h0003);
        chk("lat_dp", 32'(dp_out), 32'h1);
        chk("lat_valid", 32'(valid), 32'h1);
        chk("lat_blank", 32'(blank), 32'h0);
        chk("lat_err", 32'(err), 32'h0);
        tick(100);
        chk("hold_hex", 32'(hex_out), 32'h0003);
        chk("hold_valid", 32'(valid), 32'h1);
        chk("hold_frames", 32'(fdCount), 32'd0);

        // Full frame scan 1,2,A,F
        drive(4'b1110, 7'h06, 1'b0);
        tick(6);
        drive(4'b1101, 7'h5B, 1'b0);
        tick(6);
        drive(4'b1011, 7'h77, 1'b0);
        tick(6);
        drive(4'b0111, 7'h71, 1'b0);
        tick(4);
        chk("scan_fd_early", 32'(frame_done), 32'h0);
        tick(1);
        chk("scan_fd", 32'(frame_done), 32'h1);
        chk("scan_hex", 32'(hex_out), 32'hFA21);
        chk("scan_valid", 32'(valid), 32'hF);
        chk("scan_dp", 32'(dp_out), 32'h0);
        tick(1);
        chk("scan_fd_after", 32'(frame_done), 32'h0);
        chk("scan_frames", 32'(fdCount), 32'd1);

        // Illegal then blank on slot 2
        drive(4'b1011, 7'h01, 1'b0);
        tick(5);
        chk("ill_err", 32'(err), 32'h4);
        chk("ill_blank", 32'(blank), 32'h0);
        chk("ill_hex", 32'(hex_out), 32'hFA21);
        tick(1);
        drive(4'b1011, 7'h00, 1'b0);
        tick(5);
        chk("blk_err", 32'(err), 32'h0);
        chk("blk_blank", 32'(blank), 32'h4);
        chk("blk_hex", 32'(hex_out), 32'hFA21);
        tick(1);
        chk("blk_frames", 32'(fdCount), 32'd1);

        // Seen mask was cleared by the last frame: the next frame ends at slot 3
        drive(4'b1110, 7'h3F, 1'b0);
        tick(6);
        chk("f2_slot0_frames", 32'(fdCount), 32'd1);
        drive(4'b1101, 7'h7F, 1'b0);
        tick(6);
        chk("f2_slot1_frames", 32'(fdCount), 32'd1);
        drive(4'b0111, 7'h39, 1'b0);
        tick(5);
        chk("f2_fd", 32'(frame_done), 32'h1);
        chk("f2_hex", 32'(hex_out), 32'hCA80);
        chk("f2_blank", 32'(blank), 32'h4);
        tick(1);

        // Short glitch and multi-anode pattern
        drive(4'b1101, 7'h06, 1'b0);
        tick(3);
        drive(4'b0111, 7'h39, 1'b0);
        tick(8);
        chk("glitch_hex", 32'(hex_out), 32'hCA80);
        chk("glitch_frames", 32'(fdCount), 32'd2);
        drive(4'b1100, 7'h06, 1'b0);
        tick(10);
        chk("multi_hex", 32'(hex_out), 32'hCA80);
        chk("multi_valid", 32'(valid), 32'hF);
        chk("multi_err", 32'(err), 32'h0);
        chk("multi_blank", 32'(blank), 32'h4);
        chk("multi_frames", 32'(fdCount), 32'd2);

        // Reset in the middle of a run
        drive(4'b1101, 7'h6D, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_hex", 32'(hex_out), 32'h0000);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        tick(4);
        chk("rst_before_valid", 32'(valid), 32'h0);
        tick(1);
        chk("rst_cap_hex", 32'(hex_out), 32'h0050);
        chk("rst_cap_valid", 32'(valid), 32'h2);
        chk("rst_cap_dp", 32'(dp_out), 32'h2);
        chk("rst_cap_fd", 32'(frame_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
